// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared front-end constants and state type for the fetch PC / redirect logic.
// The decode and jump logic import the same definitions.
package fetch_redirect_ctrl_pkg;

  localparam int PC_W      = 16;
  localparam int FETCH_W   = 4;
  localparam int FLUSH_CYC = 2;
  localparam int CNT_W     = 16;
  localparam logic [PC_W-1:0] RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    RUN,
    JWAIT,
    FLUSH
  } fe_state_t;

  // Sequential fetch-group advance; wraps silently at the top of the PC space.
  function automatic logic [PC_W-1:0] seq_pc(input logic [PC_W-1:0] cur);
    return cur + PC_W'(FETCH_W);
  endfunction

endpackage

// File: rtl/fetch_redirect_ctrl_pend_buf.sv
// Single-entry redirect holding register.
// Only an empty entry accepts a new target; kill and clear both empty it.
module redirect_pend_buf
  import fetch_redirect_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            set,
  input  logic [PC_W-1:0] set_pc,
  input  logic            clr,
  input  logic            kill,
  output logic            vld,
  output logic [PC_W-1:0] pend_pc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld     <= 1'b0;
      pend_pc <= '0;
    end else if (kill || clr) begin
      vld <= 1'b0;
    end else if (set && !vld) begin
      vld     <= 1'b1;
      pend_pc <= set_pc;
    end
  end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC owner: arbitrates mispredict, buffered, jump and predictor redirects,
// parks fetch during register-based jumps and drains the front end after a mispredict.
module fetch_redirect_ctrl
  import fetch_redirect_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_stall,
  input  logic             mispredict,
  input  logic [PC_W-1:0]  mispredict_pc,
  input  logic             jmp_sel,
  input  logic [PC_W-1:0]  jmp_pc,
  input  logic             jmp_wait,
  input  logic             bp_taken,
  input  logic [PC_W-1:0]  bp_target,
  output logic [PC_W-1:0]  pc,
  output logic             fetch_en,
  output logic             flush_fe,
  output logic [CNT_W-1:0] redir_cnt
);

  fe_state_t       state;
  logic [2:0]      flush_cnt;
  logic            pend_vld;
  logic [PC_W-1:0] pend_pc;

  logic            run_cyc, enter_wait, run_go;
  logic            take_pend, take_jmp, take_bp, bump;
  logic            pend_set, pend_kill;
  logic [PC_W-1:0] pend_set_pc;

  // A jmp_sel alongside jmp_wait already carries the resume PC, so it does not park fetch.
  always_comb begin
    run_cyc     = (state == RUN) && !mispredict;
    enter_wait  = run_cyc && jmp_wait && !jmp_sel;
    run_go      = run_cyc && !enter_wait && !fetch_stall;
    take_pend   = run_go && pend_vld;
    take_jmp    = run_go && !pend_vld && jmp_sel;
    take_bp     = run_go && !pend_vld && !jmp_sel && bp_taken;
    pend_set    = run_cyc && !enter_wait && fetch_stall && (jmp_sel || bp_taken);
    pend_set_pc = jmp_sel ? jmp_pc : bp_target;
    pend_kill   = mispredict || ((state == JWAIT) && jmp_sel);
    bump        = mispredict || take_pend || take_jmp || take_bp ||
                  ((state == JWAIT) && jmp_sel);
  end

  redirect_pend_buf u_pend_buf (
    .clk     (clk),
    .rst     (rst),
    .set     (pend_set),
    .set_pc  (pend_set_pc),
    .clr     (take_pend),
    .kill    (pend_kill),
    .vld     (pend_vld),
    .pend_pc (pend_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      pc        <= RESET_PC;
      fetch_en  <= 1'b1;
      flush_fe  <= 1'b0;
      redir_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      flush_fe <= 1'b0;
      if (bump && (redir_cnt != '1)) redir_cnt <= redir_cnt + 1'b1;

      if (mispredict) begin
        pc        <= mispredict_pc;
        fetch_en  <= 1'b0;
        flush_fe  <= 1'b1;
        state     <= FLUSH;
        flush_cnt <= 3'(FLUSH_CYC);
      end else begin
        case (state)
          RUN: begin
            if (enter_wait) begin
              state    <= JWAIT;
              fetch_en <= 1'b0;
            end else if (run_go) begin
              if (take_pend) begin
                pc       <= pend_pc;
                flush_fe <= 1'b1;
              end else if (take_jmp) begin
                pc       <= jmp_pc;
                flush_fe <= 1'b1;
              end else if (take_bp) begin
                pc <= bp_target;
              end else begin
                pc <= seq_pc(pc);
              end
            end
          end
          JWAIT: begin
            if (jmp_sel) begin
              pc       <= jmp_pc;
              flush_fe <= 1'b1;
              fetch_en <= 1'b1;
              state    <= RUN;
            end else if (!jmp_wait) begin
              pc       <= seq_pc(pc);
              fetch_en <= 1'b1;
              state    <= RUN;
            end
          end
          FLUSH: begin
            if (flush_cnt <= 3'd1) begin
              state     <= RUN;
              fetch_en  <= 1'b1;
              flush_cnt <= '0;
            end else begin
              flush_cnt <= flush_cnt - 3'd1;
            end
          end
          default: begin
            state    <= RUN;
            fetch_en <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl: stimulus pushes hand-computed expectations
// into a queue, and a negedge monitor pops and compares them against the DUT outputs.
module tb_fetch_redirect_ctrl;
  import fetch_redirect_ctrl_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             fetch_stall;
  logic             mispredict;
  logic [PC_W-1:0]  mispredict_pc;
  logic             jmp_sel;
  logic [PC_W-1:0]  jmp_pc;
  logic             jmp_wait;
  logic             bp_taken;
  logic [PC_W-1:0]  bp_target;
  logic [PC_W-1:0]  pc;
  logic             fetch_en;
  logic             flush_fe;
  logic [CNT_W-1:0] redir_cnt;

  typedef struct {
    logic [PC_W-1:0]  pc;
    logic             en;
    logic             fl;
    logic [CNT_W-1:0] cnt;
    string            name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  fetch_redirect_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_stall   (fetch_stall),
    .mispredict    (mispredict),
    .mispredict_pc (mispredict_pc),
    .jmp_sel       (jmp_sel),
    .jmp_pc        (jmp_pc),
    .jmp_wait      (jmp_wait),
    .bp_taken      (bp_taken),
    .bp_target     (bp_target),
    .pc            (pc),
    .fetch_en      (fetch_en),
    .flush_fe      (flush_fe),
    .redir_cnt     (redir_cnt)
  );

  // Drive one cycle of inputs, then queue what the outputs must show after that edge.
  task automatic applyStimulus(input logic r, input logic st, input logic mp,
                               input logic [PC_W-1:0] mpc, input logic js,
                               input logic [PC_W-1:0] jpc, input logic jw,
                               input logic bt, input logic [PC_W-1:0] bpc,
                               input logic [PC_W-1:0] e_pc, input logic e_en,
                               input logic e_fl, input logic [CNT_W-1:0] e_cnt,
                               input string name);
    exp_t e;
    @(negedge clk);
    rst = r; fetch_stall = st; mispredict = mp; mispredict_pc = mpc;
    jmp_sel = js; jmp_pc = jpc; jmp_wait = jw; bp_taken = bt; bp_target = bpc;
    @(posedge clk);
    #1;
    e.pc = e_pc; e.en = e_en; e.fl = e_fl; e.cnt = e_cnt; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    n_checks += 4;
    if (pc !== e.pc) begin
      n_errors++;
      $display("[TB] FAIL %s.pc got=%h exp=%h", e.name, pc, e.pc);
    end
    if (fetch_en !== e.en) begin
      n_errors++;
      $display("[TB] FAIL %s.fetch_en got=%b exp=%b", e.name, fetch_en, e.en);
    end
    if (flush_fe !== e.fl) begin
      n_errors++;
      $display("[TB] FAIL %s.flush_fe got=%b exp=%b", e.name, flush_fe, e.fl);
    end
    if (redir_cnt !== e.cnt) begin
      n_errors++;
      $display("[TB] FAIL %s.redir_cnt got=%0d exp=%0d", e.name, redir_cnt, e.cnt);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
  end

  initial begin
    rst = 1'b1; fetch_stall = 1'b0; mispredict = 1'b0; mispredict_pc = '0;
    jmp_sel = 1'b0; jmp_pc = '0; jmp_wait = 1'b0; bp_taken = 1'b0; bp_target = '0;

    //             rst st mp mpc       js jpc       jw bt bpc        pc        en fl cnt
    applyStimulus(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, "reset");
    applyStimulus(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0004, 1, 0, 0, "seq1");
    applyStimulus(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0008, 1, 0, 0, "seq2");
    applyStimulus(0, 0, 0, 16'h0000, 1, 16'h0040, 0, 0, 16'h0000, 16'h0040, 1, 1, 1, "imm_jump");
    applyStimulus(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0044, 1, 0, 1, "jump_pulse_end");
    applyStimulus(0, 0, 0, 16'h0000, 1, 16'hFFFC, 0, 0, 16'h0000, 16'hFFFC, 1, 1, 2, "to_top");
    applyStimulus(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 2, "wrap");
    applyStimulus(0, 1, 0, 16'h0000, 1, 16'h0100, 0, 0, 16'h0000, 16'h0000, 1, 0, 2, "stall_jmp");
    applyStimulus(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0200, 16'h0000, 1, 0, 2, "stall_bp_drop");
    applyStimulus(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 2, "stall_hold");
    applyStimulus(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0100, 1, 1, 3, "stall_release");
    applyStimulus(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0104, 1, 0, 3, "after_pend");
    applyStimulus(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0500, 16'h0500, 1, 0, 4, "bp_taken");
    applyStimulus(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 16'h0500, 0, 0, 4, "jwait1");
    applyStimulus(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0600, 16'h0500, 0, 0, 4, "jwait2_bp_ign");
    applyStimulus(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 16'h0500, 0, 0, 4, "jwait3");
    applyStimulus(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 16'h0500, 0, 0, 4, "jwait4");
    applyStimulus(0, 0, 0, 16'h0000, 1, 16'h0080, 1, 0, 16'h0000, 16'h0080, 1, 1, 5, "jwait_resume");
    applyStimulus(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0084, 1, 0, 5, "resume_seq");
    applyStimulus(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 16'h0084, 0, 0, 5, "jwait_again");
    applyStimulus(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0900, 16'h0088, 1, 0, 5, "jwait_drop");
    applyStimulus(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0300, 16'h0088, 1, 0, 5, "pend_bp");
    applyStimulus(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 16'h0088, 0, 0, 5, "jwait_w_pend");
    applyStimulus(0, 0, 1, 16'h1234, 1, 16'h0700, 1, 0, 16'h0000, 16'h1234, 0, 1, 6, "mispredict");
    applyStimulus(0, 0, 0, 16'h0000, 1, 16'h0700, 0, 1, 16'h0800, 16'h1234, 0, 0, 6, "flush1");
    applyStimulus(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h1234, 1, 0, 6, "flush_exit");
    applyStimulus(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h1238, 1, 0, 6, "post_flush_seq");
    applyStimulus(0, 1, 1, 16'h2000, 0, 16'h0000, 0, 0, 16'h0000, 16'h2000, 0, 1, 7, "misp_stalled");
    applyStimulus(0, 0, 1, 16'h3000, 0, 16'h0000, 0, 0, 16'h0000, 16'h3000, 0, 1, 8, "misp_b2b");
    applyStimulus(0, 0, 0, 16'h0000, 1, 16'h0999, 0, 0, 16'h0000, 16'h3000, 0, 0, 8, "flush_jmp_ign");
    applyStimulus(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, "rst_mid_flush");
    applyStimulus(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0004, 1, 0, 0, "post_rst_run");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("[TB] FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
